// File: rtl/dc_fifo_burst_reader.sv
// Burst reader for the read side of a show-ahead dual-clock FIFO: drains fixed-length
// bursts onto a valid/ready stream, flushing a short tail after an idle timeout.
`timescale 1ns/1ps
module dc_fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  rd_clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
    output logic                  fifo_rd_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic [15:0]           bursts_o,
    output logic                  flush_o
);

    // state | meaning
    // IDLE  | waiting for a full burst of words or for the idle timer to expire
    // BURST | draining BURST_LEN words
    // FLUSH | draining the partial tail captured when the timer expired
    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

    localparam int CW = ADDR_WIDTH + 2;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [TW-1:0] TIMER_HIT_C = TW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   avail;
    logic            burst_ok, flush_ok, timer_run;

    // The presented show-ahead word is not included in the used-words count.
    assign avail     = {1'b0, fifo_used_words_i} + {{(CW-1){1'b0}}, ~fifo_empty_i};
    assign burst_ok  = (avail >= BURST_LEN_C);
    assign timer_run = !fifo_empty_i && !burst_ok;
    assign flush_ok  = (timer_q == TIMER_HIT_C) && (avail != '0) && !burst_ok;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        timer_d   = '0;
        fifo_rd_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (burst_ok) begin
                    state_d = BURST;
                    rem_d   = BURST_LEN_C;
                end else if (flush_ok) begin
                    state_d = FLUSH;
                    rem_d   = avail;
                end else if (timer_run) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BURST, FLUSH: begin
                fifo_rd_o = !fifo_empty_i && (!m_valid_o || m_ready_i);
                if (fifo_rd_o) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
        end
    end

    // Output register doubles as a one-deep skid: a pop only happens when it is free or draining.
    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            bursts_o  <= '0;
        end else begin
            if (fifo_rd_o) begin
                m_data_o  <= fifo_data_i;
                m_valid_o <= 1'b1;
                m_last_o  <= (rem_q == CW'(1));
            end else if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
            end
            if (m_valid_o && m_ready_i && m_last_o) bursts_o <= bursts_o + 16'd1;
        end
    end

    assign flush_o = (state_q == FLUSH);

endmodule

// File: tb/tb_dc_fifo_burst_reader.sv
// Directed bench for dc_fifo_burst_reader: behavioural show-ahead FIFO on the input,
// scoreboard of expected beats checked on the stream output.
`timescale 1ns/1ps
module tb_dc_fifo_burst_reader;

    logic       rd_clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] fifo_data_i;
    logic       fifo_empty_i;
    logic [3:0] fifo_used_words_i;
    logic       fifo_rd_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_last_o;
    logic       m_ready_i;
    logic [15:0] bursts_o;
    logic       flush_o;

    dc_fifo_burst_reader dut (
        .rd_clk_i         (rd_clk_i),
        .rst_i            (rst_i),
        .fifo_data_i      (fifo_data_i),
        .fifo_empty_i     (fifo_empty_i),
        .fifo_used_words_i(fifo_used_words_i),
        .fifo_rd_o        (fifo_rd_o),
        .m_data_o         (m_data_o),
        .m_valid_o        (m_valid_o),
        .m_last_o         (m_last_o),
        .m_ready_i        (m_ready_i),
        .bursts_o         (bursts_o),
        .flush_o          (flush_o)
    );

    always #5 rd_clk_i = ~rd_clk_i;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic [7:0] fq[$];
    beat_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         beat_cnt = 0;
    int         first_cyc = 0;
    int         last_cyc = 0;
    logic       hold_empty = 1'b0;
    logic       pop_req = 1'b0;
    logic       flush_seen = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        if (hold_empty || fq.size() == 0) begin
            fifo_empty_i      = 1'b1;
            fifo_data_i       = 8'h00;
            fifo_used_words_i = 4'd0;
        end else begin
            fifo_empty_i      = 1'b0;
            fifo_data_i       = fq[0];
            fifo_used_words_i = 4'(fq.size() - 1);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fq.push_back(d);
        refresh();
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge rd_clk_i);
        #2;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid_o) && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    always @(posedge rd_clk_i) cyc++;

    // Behavioural show-ahead FIFO: pop decision sampled mid-cycle, applied just after the edge.
    always @(negedge rd_clk_i) pop_req = fifo_rd_o;
    always @(posedge rd_clk_i) begin
        #1;
        if (pop_req && !hold_empty && fq.size() != 0) begin
            fq.delete(0);
            pop_cnt++;
        end
        refresh();
    end

    always @(negedge rd_clk_i) begin
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (fifo_empty_i) chk("rd_while_empty", fifo_rd_o, 1'b0);
            if (flush_o) flush_seen = 1'b1;
            if (stall_prev && m_valid_o) begin
                chk("stall_data_stable", m_data_o, stall_data);
                chk("stall_last_stable", m_last_o, stall_last);
            end
            stall_prev = m_valid_o && !m_ready_i;
            stall_data = m_data_o;
            stall_last = m_last_o;
            if (m_valid_o && m_ready_i) begin
                chk("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    chk("beat_data", m_data_o, exp_q[0].d);
                    chk("beat_last", m_last_o, exp_q[0].l);
                    exp_q.delete(0);
                end
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i     = 1'b1;
        m_ready_i = 1'b1;
        refresh();
        repeat (3) tick();
        chk("rst_valid", m_valid_o, 1'b0);
        chk("rst_last", m_last_o, 1'b0);
        chk("rst_data", m_data_o, 8'h00);
        chk("rst_bursts", bursts_o, 16'd0);
        chk("rst_flush", flush_o, 1'b0);
        chk("rst_rd", fifo_rd_o, 1'b0);
        rst_i = 1'b0;
        tick();

        // Full burst of four with the sink always ready.
        beat_cnt = 0;
        flush_seen = 1'b0;
        for (int i = 0; i < 4; i++) expect_beat(8'hA0 + 8'(i), i == 3);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        tick();
        chk("t1_first_pop", fifo_rd_o, 1'b1);
        chk("t1_valid_before_pop", m_valid_o, 1'b0);
        tick();
        chk("t1_valid_after_pop", m_valid_o, 1'b1);
        drain("t1", 40);
        chk("t1_bursts", bursts_o, 16'd1);
        chk("t1_no_flush", flush_seen, 1'b0);
        chk("t1_throughput", last_cyc - first_cyc, 3);

        // Two words only: flush after the idle timeout.
        flush_seen = 1'b0;
        expect_beat(8'hB0, 1'b0);
        expect_beat(8'hB1, 1'b1);
        push(8'hB0);
        push(8'hB1);
        repeat (15) tick();
        chk("t2_no_early_flush", flush_o, 1'b0);
        tick();
        chk("t2_flush_enter", flush_o, 1'b1);
        drain("t2", 40);
        chk("t2_bursts", bursts_o, 16'd2);
        chk("t2_flush_seen", flush_seen, 1'b1);

        // Eight words with the sink toggling ready every cycle.
        for (int i = 0; i < 8; i++) expect_beat(8'hC0 + 8'(i), i == 3 || i == 7);
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        begin
            int n = 0;
            while ((exp_q.size() != 0 || m_valid_o) && n < 200) begin
                m_ready_i = !m_ready_i;
                tick();
                n++;
            end
        end
        m_ready_i = 1'b1;
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_bursts", bursts_o, 16'd4);

        // FIFO reports empty for five cycles in the middle of a burst.
        flush_seen = 1'b0;
        beat_cnt = 0;
        for (int i = 0; i < 4; i++) expect_beat(8'hD0 + 8'(i), i == 3);
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
        tick();
        tick();
        hold_empty = 1'b1;
        refresh();
        repeat (5) begin
            tick();
            chk("t4_rd_during_empty", fifo_rd_o, 1'b0);
        end
        chk("t4_stalled_beats", beat_cnt, 1);
        hold_empty = 1'b0;
        refresh();
        drain("t4", 40);
        chk("t4_no_flush", flush_seen, 1'b0);
        chk("t4_bursts", bursts_o, 16'd5);

        // Reset after two pops: the pending second word is discarded, the tail flushes.
        pop_cnt = 0;
        expect_beat(8'hE0, 1'b0);
        expect_beat(8'hE2, 1'b0);
        expect_beat(8'hE3, 1'b1);
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
        begin
            int n = 0;
            while (pop_cnt < 2 && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t5_pops_before_reset", pop_cnt, 2);
        rst_i = 1'b1;
        #1;
        chk("t5_rst_valid", m_valid_o, 1'b0);
        chk("t5_rst_last", m_last_o, 1'b0);
        chk("t5_rst_data", m_data_o, 8'h00);
        chk("t5_rst_bursts", bursts_o, 16'd0);
        chk("t5_rst_flush", flush_o, 1'b0);
        chk("t5_rst_rd", fifo_rd_o, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;
        flush_seen = 1'b0;
        drain("t5", 60);
        chk("t5_bursts", bursts_o, 16'd1);
        chk("t5_flush_seen", flush_seen, 1'b1);

        // Trickle: an empty gap clears the timer, then 16 non-empty cycles are needed.
        flush_seen = 1'b0;
        expect_beat(8'hF0, 1'b0);
        expect_beat(8'hF1, 1'b1);
        push(8'hF0);
        repeat (10) tick();
        chk("t6_no_flush_pre_gap", flush_o, 1'b0);
        hold_empty = 1'b1;
        refresh();
        repeat (3) tick();
        hold_empty = 1'b0;
        refresh();
        repeat (10) tick();
        push(8'hF1);
        repeat (5) tick();
        chk("t6_no_early_flush", flush_o, 1'b0);
        tick();
        chk("t6_flush_enter", flush_o, 1'b1);
        drain("t6", 40);
        chk("t6_bursts", bursts_o, 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dc_fifo_burst_reader.md
DC_FIFO_BURST_READER -- requirements
Module: dc_fifo_burst_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO and stream data.
REQ-002 Parameter ADDR_WIDTH, default 3, FIFO address width; the used-words input is ADDR_WIDTH+1 bits.
REQ-003 Parameter BURST_LEN, default 4, words per full burst; legal range 1..2**ADDR_WIDTH.
REQ-004 Parameter TIMEOUT, default 16, idle cycles before a partial (flush) burst; legal range >= 2.
REQ-005 rd_clk_i  input  1  read-domain clock; all logic rising-edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 fifo_data_i  input  DATA_WIDTH  show-ahead FIFO read data, valid while fifo_empty_i=0.
REQ-008 fifo_empty_i  input  1  FIFO read-side empty flag.
REQ-009 fifo_used_words_i  input  ADDR_WIDTH+1  FIFO read-side used words, excluding the word already presented on fifo_data_i.
REQ-010 fifo_rd_o  output  1  pop request; the FIFO presents the next word on the following cycle.
REQ-011 m_data_o  output  DATA_WIDTH  stream data, registered.
REQ-012 m_valid_o  output  1  stream valid, registered.
REQ-013 m_last_o  output  1  marks the final word of a burst, registered.
REQ-014 m_ready_i  input  1  stream ready from the downstream sink.
REQ-015 bursts_o  output  16  count of completed bursts (full + flush), wraps at 2**16.
REQ-016 flush_o  output  1  high while the current burst is a flush burst.

Function
REQ-017 Available words avail SHALL be fifo_used_words_i + (fifo_empty_i ? 0 : 1), computed ADDR_WIDTH+2 bits wide, no overflow.
REQ-018 FSM states SHALL be IDLE, BURST, FLUSH; reset state IDLE.
REQ-019 IDLE -> BURST SHALL occur when avail >= BURST_LEN; remaining counter loads BURST_LEN.
REQ-020 Idle timer SHALL increment each IDLE cycle with fifo_empty_i=0 and avail < BURST_LEN, and clear to 0 otherwise and on leaving IDLE.
REQ-021 IDLE -> FLUSH SHALL occur when the timer equals TIMEOUT-1 and avail >= 1 and avail < BURST_LEN; remaining loads avail.
REQ-022 If BURST and FLUSH conditions coincide, BURST SHALL win.
REQ-023 No pop SHALL occur in IDLE; fifo_rd_o = 0 there.
REQ-024 In BURST/FLUSH, fifo_rd_o SHALL be (!fifo_empty_i) && (!m_valid_o || m_ready_i); combinational, same cycle.
REQ-025 On a pop, m_data_o <= fifo_data_i, m_valid_o <= 1, m_last_o <= (remaining == 1), remaining decrements by 1.
REQ-026 On the pop with remaining == 1, the FSM SHALL return to IDLE the next cycle.
REQ-027 If m_valid_o && m_ready_i with no pop, m_valid_o <= 0 and m_last_o <= 0.
REQ-028 While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o SHALL hold stable.
REQ-029 fifo_empty_i=1 mid-burst SHALL stall without pops; the burst resumes when data returns, with no timeout.
REQ-030 bursts_o SHALL increment by 1 on each cycle with m_valid_o && m_ready_i && m_last_o.
REQ-031 flush_o SHALL be 1 exactly while state == FLUSH.
REQ-032 Throughput: with m_ready_i held at 1 and the FIFO non-empty, one word per cycle.
REQ-033 Latency: first pop in the cycle after entering BURST/FLUSH; m_valid_o rises one cycle after that pop.

Reset
REQ-034 rst_i=1 SHALL asynchronously force state IDLE, timer 0, remaining 0, m_valid_o 0, m_last_o 0, m_data_o 0, bursts_o 0, flush_o 0, fifo_rd_o 0.
REQ-035 Reset mid-burst SHALL discard any pending output word; after deassertion, operation restarts from IDLE using the current avail.

Verification
REQ-036 FIFO holds 4 words (0xA0..0xA3), m_ready_i=1 -> four consecutive beats A0..A3, m_last_o only on A3, bursts_o=1, flush_o never 1.
REQ-037 FIFO holds 2 words, none added -> after 16 idle cycles, FLUSH; 2 beats, last on the second; flush_o=1 during the burst; bursts_o=1.
REQ-038 8 words, m_ready_i toggling 1/0 each cycle -> no data loss or duplication; two bursts of 4; each m_last_o on the 4th word; stable data while stalled.
REQ-039 Mid-burst fifo_empty_i=1 for 5 cycles -> fifo_rd_o=0 and the burst stalls; it completes with the correct remaining words; no FLUSH is entered.
REQ-040 rst_i pulsed after 2 of 4 beats -> outputs 0 immediately; after release with 2 words left (avail < 4), a flush burst of 2 follows the timeout.
REQ-041 Words trickle in one per 10 cycles -> the timer clears while the FIFO is empty; a flush triggers only after 16 consecutive non-empty idle cycles.
